// File: rtl/ni_pkg.sv
// Shared definitions for the NI transmit packetizer: FSM states, flit type
// codes and head-flit field placement (offsets counted from the payload MSB).
package ni_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HEAD  = 3'd1,
        ST_FETCH = 3'd2,
        ST_WAIT  = 3'd3,
        ST_SEND  = 3'd4
    } tx_state_e;

    typedef enum logic [1:0] {
        FLIT_BODY = 2'b00,
        FLIT_HEAD = 2'b01,
        FLIT_TAIL = 2'b10
    } flit_type_e;

    localparam int HDR_DX_W    = 4;
    localparam int HDR_DY_W    = 4;
    localparam int HDR_SRC_W   = 8;
    localparam int HDR_DX_TOP  = 0;
    localparam int HDR_DY_TOP  = 4;
    localparam int HDR_SRC_TOP = 8;
    localparam int HDR_LEN_TOP = 16;

endpackage

// File: rtl/ni_tx_packetizer_if.sv
// FIFO-side and router-side handshake signals of the NI transmit packetizer.
interface ni_tx_packetizer_if #(
    parameter int DATA_WIDTH = 64
) ();
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_rd_en;
    logic [DATA_WIDTH+1:0] flit_out;
    logic                  flit_valid;
    logic                  flit_ready;

    modport master (
        input  fifo_empty, fifo_data, flit_ready,
        output fifo_rd_en, flit_out, flit_valid
    );

    modport slave (
        output fifo_empty, fifo_data, flit_ready,
        input  fifo_rd_en, flit_out, flit_valid
    );
endinterface

// File: rtl/ni_tx_packetizer.sv
// Pops payload words from the NI FIFO and emits head/body/tail flits toward
// the router; the packet configuration is latched when a packet starts.
module ni_tx_packetizer
    import ni_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int LEN_W      = 5
) (
    input  logic                clk,
    input  logic                reset,
    ni_tx_packetizer_if.master  bus,
    input  logic [3:0]          dest_x,
    input  logic [3:0]          dest_y,
    input  logic [7:0]          src_id,
    input  logic [LEN_W-1:0]    pkt_len,
    output logic                busy,
    output logic [15:0]         pkt_count
);

    localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

    tx_state_e             state_r;
    logic [LEN_W-1:0]      remaining_r;
    logic [3:0]            dx_r;
    logic [3:0]            dy_r;
    logic [7:0]            src_r;
    logic [LEN_W-1:0]      len_r;
    logic [DATA_WIDTH+1:0] flit_out_r;
    logic                  flit_valid_r;
    logic [15:0]           pkt_count_r;
    logic                  xfer_s;

    function automatic logic [DATA_WIDTH-1:0] head_payload(
        input logic [3:0]       dx,
        input logic [3:0]       dy,
        input logic [7:0]       src,
        input logic [LEN_W-1:0] len
    );
        logic [DATA_WIDTH-1:0] p;
        p = '0;
        p[DATA_WIDTH-1-HDR_DX_TOP  -: HDR_DX_W]  = dx;
        p[DATA_WIDTH-1-HDR_DY_TOP  -: HDR_DY_W]  = dy;
        p[DATA_WIDTH-1-HDR_SRC_TOP -: HDR_SRC_W] = src;
        p[DATA_WIDTH-1-HDR_LEN_TOP -: LEN_W]     = len;
        return p;
    endfunction

    assign xfer_s         = flit_valid_r & bus.flit_ready;
    assign bus.fifo_rd_en = (state_r == ST_FETCH) & ~bus.fifo_empty;
    assign bus.flit_out   = flit_out_r;
    assign bus.flit_valid = flit_valid_r;
    assign busy           = (state_r != ST_IDLE);
    assign pkt_count      = pkt_count_r;

    // Packet FSM with its registered flit, length and counter state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            remaining_r  <= '0;
            dx_r         <= 4'd0;
            dy_r         <= 4'd0;
            src_r        <= 8'd0;
            len_r        <= '0;
            flit_out_r   <= '0;
            flit_valid_r <= 1'b0;
            pkt_count_r  <= 16'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (!bus.fifo_empty) begin
                        dx_r         <= dest_x;
                        dy_r         <= dest_y;
                        src_r        <= src_id;
                        len_r        <= pkt_len;
                        flit_out_r   <= {FLIT_HEAD, head_payload(dest_x, dest_y, src_id, pkt_len)};
                        flit_valid_r <= 1'b1;
                        state_r      <= ST_HEAD;
                    end
                end
                ST_HEAD: begin
                    if (xfer_s) begin
                        flit_valid_r <= 1'b0;
                        remaining_r  <= (len_r == '0) ? LEN_ONE : len_r;
                        state_r      <= ST_FETCH;
                    end else begin
                        // Held head is rebuilt from the latched fields only.
                        flit_out_r <= {FLIT_HEAD, head_payload(dx_r, dy_r, src_r, len_r)};
                    end
                end
                ST_FETCH: begin
                    if (!bus.fifo_empty) begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    flit_out_r   <= {((remaining_r == LEN_ONE) ? FLIT_TAIL : FLIT_BODY), bus.fifo_data};
                    flit_valid_r <= 1'b1;
                    state_r      <= ST_SEND;
                end
                ST_SEND: begin
                    if (xfer_s) begin
                        flit_valid_r <= 1'b0;
                        remaining_r  <= remaining_r - LEN_ONE;
                        if (remaining_r == LEN_ONE) begin
                            pkt_count_r <= pkt_count_r + 16'd1;
                            state_r     <= ST_IDLE;
                        end else begin
                            state_r <= ST_FETCH;
                        end
                    end
                end
                default: begin
                    flit_valid_r <= 1'b0;
                    state_r      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ni_tx_packetizer.sv
// Randomized bench for ni_tx_packetizer: a FIFO model feeds words and a
// packet-level reference model predicts the flit stream and counters.
module tb_ni_tx_packetizer;
    import ni_pkg::*;

    localparam int DW = 64;
    localparam int LW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic [3:0]    dest_x;
    logic [3:0]    dest_y;
    logic [7:0]    src_id;
    logic [LW-1:0] pkt_len;
    logic          busy;
    logic [15:0]   pkt_count;

    ni_tx_packetizer_if #(.DATA_WIDTH(DW)) bus ();

    ni_tx_packetizer #(.DATA_WIDTH(DW), .LEN_W(LW)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .dest_x    (dest_x),
        .dest_y    (dest_y),
        .src_id    (src_id),
        .pkt_len   (pkt_len),
        .busy      (busy),
        .pkt_count (pkt_count)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Upstream FIFO model: registered read data one cycle after the pop.
    logic [DW-1:0] fifo_mem [0:255];
    int            wr_ptr     = 0;
    int            rd_ptr     = 0;
    int            rd_pulses  = 0;
    logic          fifo_flush = 1'b0;

    assign bus.fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_flush) begin
            rd_ptr <= wr_ptr;
        end else if (bus.fifo_rd_en && (wr_ptr != rd_ptr)) begin
            bus.fifo_data <= fifo_mem[rd_ptr % 256];
            rd_ptr        <= rd_ptr + 1;
        end
        if (bus.fifo_rd_en) rd_pulses <= rd_pulses + 1;
    end

    task automatic push_word(input logic [DW-1:0] w);
        fifo_mem[wr_ptr % 256] = w;
        wr_ptr++;
    endtask

    // Reference model state: expected flit stream and packet counter.
    logic [DW+1:0] exp_q [$];
    logic [DW-1:0] pend_q [$];
    logic [15:0]   model_count = 16'd0;
    logic [DW+1:0] prev_flit;
    logic          prev_hold = 1'b0;

    // Flit monitor: order/content, hold-while-stalled and pop legality.
    always @(negedge clk) begin
        if (reset) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check_eq("hold_valid", 128'(bus.flit_valid), 128'(1'b1));
                check_eq("hold_flit", 128'(bus.flit_out), 128'(prev_flit));
            end
            if (bus.fifo_rd_en) begin
                check_eq("rd_en_while_empty", 128'(bus.fifo_empty), 128'(1'b0));
                check_eq("rd_en_while_valid", 128'(bus.flit_valid), 128'(1'b0));
            end
            if (bus.flit_valid && bus.flit_ready) begin
                check_eq("flit_expected", 128'(exp_q.size() != 0), 128'(1'b1));
                if (exp_q.size() != 0) check_eq("flit_data", 128'(bus.flit_out), 128'(exp_q.pop_front()));
            end
            prev_hold = bus.flit_valid && !bus.flit_ready;
            prev_flit = bus.flit_out;
        end
    end

    function automatic logic [DW+1:0] head_of(input logic [3:0] dx, input logic [3:0] dy,
                                              input logic [7:0] src, input logic [LW-1:0] len);
        return {2'b01, dx, dy, src, len, 43'd0};
    endfunction

    // Builds the expected stream for one packet and queues its payload words.
    task automatic plan_packet(input logic [3:0] dx, input logic [3:0] dy,
                               input logic [7:0] src, input logic [LW-1:0] len, output int n);
        logic [DW-1:0] w;
        n = (len == 0) ? 1 : int'(len);
        exp_q.push_back(head_of(dx, dy, src, len));
        pend_q.delete();
        for (int i = 0; i < n; i++) begin
            w = {$urandom, $urandom};
            pend_q.push_back(w);
            exp_q.push_back({((i == n - 1) ? 2'b10 : 2'b00), w});
        end
        dest_x  = dx;
        dest_y  = dy;
        src_id  = src;
        pkt_len = len;
    endtask

    // mode: 0 always ready, 1 random ready, 2 ready dropped 5 cycles over a body.
    task automatic run_packet(input logic [3:0] dx, input logic [3:0] dy, input logic [7:0] src,
                              input logic [LW-1:0] len, input int mode, input bit underflow);
        int n;
        int start_pulses;
        int cyc;
        int stall;
        bit uf;
        plan_packet(dx, dy, src, len, n);
        uf = underflow && (n >= 2);
        start_pulses = rd_pulses;
        bus.flit_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        if (uf) push_word(pend_q.pop_front());
        else while (pend_q.size() != 0) push_word(pend_q.pop_front());
        @(posedge clk); #2;
        check_eq("head_latency", 128'(bus.flit_valid), 128'(1'b1));
        check_eq("head_flit", 128'(bus.flit_out), 128'(head_of(dx, dy, src, len)));
        check_eq("busy_in_pkt", 128'(busy), 128'(1'b1));
        cyc   = 0;
        stall = 0;
        while (exp_q.size() != 0 && cyc < 400) begin
            @(posedge clk); #2;
            cyc++;
            dest_x  = 4'($urandom);
            dest_y  = 4'($urandom);
            src_id  = 8'($urandom);
            pkt_len = LW'($urandom);
            case (mode)
                1:       bus.flit_ready = 1'($urandom_range(0, 1));
                2:       bus.flit_ready = !(cyc >= 3 && cyc < 8);
                default: bus.flit_ready = 1'b1;
            endcase
            if (uf && pend_q.size() != 0 && exp_q.size() == n - 1) begin
                stall++;
                if (stall == 6) begin
                    check_eq("underflow_no_flit", 128'(bus.flit_valid), 128'(1'b0));
                    check_eq("underflow_busy", 128'(busy), 128'(1'b1));
                    check_eq("underflow_pops", 128'(rd_pulses - start_pulses), 128'(1));
                    while (pend_q.size() != 0) push_word(pend_q.pop_front());
                end
            end
        end
        check_eq("pkt_complete", 128'(exp_q.size()), 128'(0));
        exp_q.delete();
        model_count = model_count + 16'd1;
        check_eq("busy_after_pkt", 128'(busy), 128'(1'b0));
        check_eq("pkt_count", 128'(pkt_count), 128'(model_count));
        check_eq("pops_per_pkt", 128'(rd_pulses - start_pulses), 128'(n));
        @(posedge clk); #2;
    endtask

    task automatic reset_mid_send();
        int n;
        int cyc;
        plan_packet(4'd7, 4'd1, 8'h3C, 5'd4, n);
        bus.flit_ready = 1'b1;
        while (pend_q.size() != 0) push_word(pend_q.pop_front());
        cyc = 0;
        while (!(bus.flit_valid && bus.flit_out[DW+1:DW] == 2'b00) && cyc < 50) begin
            @(posedge clk); #2;
            cyc++;
        end
        check_eq("reached_send", 128'(cyc < 50), 128'(1'b1));
        bus.flit_ready = 1'b0;
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        check_eq("rst_flit_valid", 128'(bus.flit_valid), 128'(1'b0));
        check_eq("rst_flit_out", 128'(bus.flit_out), 128'(0));
        check_eq("rst_busy", 128'(busy), 128'(1'b0));
        check_eq("rst_pkt_count", 128'(pkt_count), 128'(0));
        check_eq("rst_rd_en", 128'(bus.fifo_rd_en), 128'(1'b0));
        fifo_flush = 1'b1;
        exp_q.delete();
        model_count = 16'd0;
        @(posedge clk); #2;
        fifo_flush = 1'b0;
        reset      = 1'b0;
        @(posedge clk); #2;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int mode;
        reset          = 1'b1;
        bus.flit_ready = 1'b0;
        dest_x         = 4'd0;
        dest_y         = 4'd0;
        src_id         = 8'd0;
        pkt_len        = '0;
        repeat (3) @(posedge clk);
        #2;
        check_eq("reset_flit_valid", 128'(bus.flit_valid), 128'(1'b0));
        check_eq("reset_flit_out", 128'(bus.flit_out), 128'(0));
        check_eq("reset_busy", 128'(busy), 128'(1'b0));
        check_eq("reset_pkt_count", 128'(pkt_count), 128'(0));
        check_eq("reset_rd_en", 128'(bus.fifo_rd_en), 128'(1'b0));
        reset = 1'b0;
        @(posedge clk); #2;

        run_packet(4'd2, 4'd5, 8'h11, 5'd3, 0, 1'b0);
        run_packet(4'd9, 4'd3, 8'hA0, 5'd0, 0, 1'b0);
        run_packet(4'd1, 4'd14, 8'h42, 5'd4, 2, 1'b0);
        run_packet(4'd6, 4'd6, 8'h77, 5'd4, 0, 1'b1);
        reset_mid_send();
        run_packet(4'd3, 4'd8, 8'h05, 5'd2, 0, 1'b0);

        for (int i = 0; i < 20; i++) begin
            mode = int'($urandom_range(0, 2));
            run_packet(4'($urandom), 4'($urandom), 8'($urandom), LW'($urandom_range(0, 16)),
                       mode, 1'($urandom_range(0, 1)));
        end

        force dut.pkt_count_r = 16'hFFFE;
        @(posedge clk); #2;
        release dut.pkt_count_r;
        model_count = 16'hFFFE;
        run_packet(4'd0, 4'd0, 8'h01, 5'd1, 0, 1'b0);
        run_packet(4'd15, 4'd15, 8'hFF, 5'd1, 0, 1'b0);
        check_eq("count_wrap_zero", 128'(pkt_count), 128'(16'h0000));
        run_packet(4'd4, 4'd2, 8'h10, 5'd0, 1, 1'b0);
        check_eq("count_after_wrap", 128'(pkt_count), 128'(16'h0001));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
